// File: rtl/sisc_fetch_unit.sv
// sisc_fetch_unit: instruction-fetch stage ahead of the SISC control FSM.
// Owns the PC and the instruction register, runs a variable-latency
// req/ack handshake to instruction memory and carries out the FSM's PC commands.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   ir_load             fetch request, sampled in IDLE
//   pc_rst              synchronous PC clear, highest priority; aborts a fetch
//   pc_write            load PC from pc_in
//   pc_sel              pc_in select: 0 = pc_out+1, 1 = br_addr
//   br_sel              br_addr select: 0 = pc_out+imm, 1 = imm
//   imem_ack/imem_rdata memory response, one-cycle pulse with data
//   imem_req/imem_addr  registered memory request
//   pc_out              current PC
//   opcode..imm         IR field slices
//   ir_valid            one-cycle pulse once the IR holds a new word
//   fetch_busy          high while a request is outstanding
//   halted, fetch_err   sticky status, cleared only by rst
module sisc_fetch_unit #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned INSTR_W = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ir_load,
    input  logic               pc_rst,
    input  logic               pc_write,
    input  logic               pc_sel,
    input  logic               br_sel,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [ADDR_W-1:0]  pc_out,
    output logic [3:0]         opcode,
    output logic [3:0]         mm,
    output logic [3:0]         rd,
    output logic [3:0]         rs,
    output logic [3:0]         rt,
    output logic [15:0]        imm,
    output logic               ir_valid,
    output logic               fetch_busy,
    output logic               halted,
    output logic               fetch_err
);

    localparam int unsigned CNT_W = 8;
    localparam logic [3:0]  OP_HALT = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0]   ir_q, ir_d;
    logic                 imem_req_q, imem_req_d;
    logic [ADDR_W-1:0]    imem_addr_q, imem_addr_d;
    logic                 ir_valid_q, ir_valid_d;
    logic                 halted_q, halted_d;
    logic                 fetch_err_q, fetch_err_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic                 start_c;
    logic                 done_c;
    logic                 abort_c;
    logic                 timeout_c;
    logic                 halt_op_c;
    logic [ADDR_W-1:0]    pc_plus1_c;
    logic [ADDR_W-1:0]    imm_ext_c;
    logic [ADDR_W-1:0]    br_addr_c;
    logic [ADDR_W-1:0]    pc_in_c;

    // Handshake events; an ack always wins over abort and timeout.
    always_comb begin
        start_c   = (state_q == S_IDLE) && ir_load && !pc_rst && !halted_q && !fetch_err_q;
        done_c    = (state_q == S_REQ) && imem_ack;
        abort_c   = (state_q == S_REQ) && !imem_ack && pc_rst;
        timeout_c = (state_q == S_REQ) && !imem_ack && !pc_rst
                    && (cnt_q == CNT_W'(TIMEOUT - 1));
        halt_op_c = (imem_rdata[31:28] == OP_HALT);
    end

    // Branch target and PC input mux; all sums wrap modulo 2^ADDR_W.
    always_comb begin
        pc_plus1_c = pc_q + ADDR_W'(1);
        imm_ext_c  = ADDR_W'(ir_q[15:0]);
        br_addr_c  = br_sel ? imm_ext_c : (pc_q + imm_ext_c);
        pc_in_c    = pc_sel ? br_addr_c : pc_plus1_c;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_c) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (done_c) begin
                    state_d = halt_op_c ? S_HALT : S_IDLE;
                end else if (abort_c || timeout_c) begin
                    state_d = S_IDLE;
                end
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // Output / datapath next values.
    always_comb begin
        imem_req_d  = imem_req_q;
        imem_addr_d = imem_addr_q;
        ir_d        = ir_q;
        ir_valid_d  = 1'b0;
        halted_d    = halted_q;
        fetch_err_d = fetch_err_q;
        cnt_d       = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (start_c) begin
                    imem_req_d  = 1'b1;
                    imem_addr_d = pc_q;
                    cnt_d       = '0;
                end
            end
            S_REQ: begin
                if (done_c) begin
                    ir_d       = imem_rdata;
                    imem_req_d = 1'b0;
                    ir_valid_d = 1'b1;
                    if (halt_op_c) begin
                        halted_d = 1'b1;
                    end
                end else if (abort_c) begin
                    imem_req_d = 1'b0;
                end else if (timeout_c) begin
                    imem_req_d  = 1'b0;
                    fetch_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
            end
        endcase

        // PC priority: clear, explicit write, fetch auto-increment, hold.
        if (pc_rst) begin
            pc_d = '0;
        end else if (pc_write) begin
            pc_d = pc_in_c;
        end else if (done_c) begin
            pc_d = pc_plus1_c;
        end else begin
            pc_d = pc_q;
        end
    end

    // Datapath and status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q        <= '0;
            ir_q        <= '0;
            imem_req_q  <= 1'b0;
            imem_addr_q <= '0;
            ir_valid_q  <= 1'b0;
            halted_q    <= 1'b0;
            fetch_err_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            imem_req_q  <= imem_req_d;
            imem_addr_q <= imem_addr_d;
            ir_valid_q  <= ir_valid_d;
            halted_q    <= halted_d;
            fetch_err_q <= fetch_err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign imem_req   = imem_req_q;
    assign imem_addr  = imem_addr_q;
    assign pc_out     = pc_q;
    assign ir_valid   = ir_valid_q;
    assign halted     = halted_q;
    assign fetch_err  = fetch_err_q;
    assign fetch_busy = (state_q == S_REQ);

    assign opcode = ir_q[31:28];
    assign mm     = ir_q[27:24];
    assign rd     = ir_q[23:20];
    assign rs     = ir_q[19:16];
    assign rt     = ir_q[15:12];
    assign imm    = ir_q[15:0];

endmodule

// File: tb/tb_sisc_fetch_unit.sv
// Self-checking bench for sisc_fetch_unit: table of fetch/PC-write vectors,
// hand-written sequences for abort, timeout, halt and reset corner cases,
// and a scoreboard queue of expected IR words popped on each ir_valid pulse.
module tb_sisc_fetch_unit;

    logic        clk;
    logic        rst;
    logic        ir_load;
    logic        pc_rst;
    logic        pc_write;
    logic        pc_sel;
    logic        br_sel;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] pc_out;
    logic [3:0]  opcode;
    logic [3:0]  mm;
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic [3:0]  rt;
    logic [15:0] imm;
    logic        ir_valid;
    logic        fetch_busy;
    logic        halted;
    logic        fetch_err;

    int total;
    int bad;
    logic [31:0] exp_q[$];

    sisc_fetch_unit #(.ADDR_W(16), .INSTR_W(32), .TIMEOUT(15)) dut (
        .clk        (clk),
        .rst        (rst),
        .ir_load    (ir_load),
        .pc_rst     (pc_rst),
        .pc_write   (pc_write),
        .pc_sel     (pc_sel),
        .br_sel     (br_sel),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .pc_out     (pc_out),
        .opcode     (opcode),
        .mm         (mm),
        .rd         (rd),
        .rs         (rs),
        .rt         (rt),
        .imm        (imm),
        .ir_valid   (ir_valid),
        .fetch_busy (fetch_busy),
        .halted     (halted),
        .fetch_err  (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every ir_valid pulse must match the oldest acked word.
    always @(negedge clk) begin
        if (ir_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL ir_valid_unexpected: got ir %0h expected no pulse",
                         {opcode, mm, rd, rs, imm});
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                chk("ir_word", {opcode, mm, rd, rs, imm}, e);
                chk("ir_rt", 32'(rt), 32'(e[15:12]));
            end
        end
    end

    task automatic check_reset(input string tag);
        chk({tag, "_req"}, 32'(imem_req), 32'd0);
        chk({tag, "_addr"}, 32'(imem_addr), 32'd0);
        chk({tag, "_pc"}, 32'(pc_out), 32'd0);
        chk({tag, "_ir"}, {opcode, mm, rd, rs, imm}, 32'd0);
        chk({tag, "_valid"}, 32'(ir_valid), 32'd0);
        chk({tag, "_busy"}, 32'(fetch_busy), 32'd0);
        chk({tag, "_halted"}, 32'(halted), 32'd0);
        chk({tag, "_err"}, 32'(fetch_err), 32'd0);
    endtask

    // Issue a fetch at exp_addr; memory acks after lat request cycles.
    task automatic fetch(input int lat, input logic [31:0] rdata, input logic [15:0] exp_addr,
                         input logic [15:0] exp_pc, input logic wr_on_ack, input logic rst_on_ack);
        ir_load = 1'b1;
        tick();
        ir_load = 1'b0;
        chk("fetch_req", 32'(imem_req), 32'd1);
        chk("fetch_addr", 32'(imem_addr), 32'(exp_addr));
        chk("fetch_busy", 32'(fetch_busy), 32'd1);
        for (int i = 1; i < lat; i++) begin
            tick();
            chk("fetch_req_hold", 32'(imem_req), 32'd1);
            chk("fetch_addr_hold", 32'(imem_addr), 32'(exp_addr));
        end
        imem_ack   = 1'b1;
        imem_rdata = rdata;
        pc_write   = wr_on_ack;
        pc_sel     = wr_on_ack;
        br_sel     = wr_on_ack;
        pc_rst     = rst_on_ack;
        exp_q.push_back(rdata);
        tick();
        imem_ack = 1'b0;
        pc_write = 1'b0;
        pc_sel   = 1'b0;
        br_sel   = 1'b0;
        pc_rst   = 1'b0;
        chk("fetch_req_drop", 32'(imem_req), 32'd0);
        chk("fetch_valid", 32'(ir_valid), 32'd1);
        chk("fetch_pc", 32'(pc_out), 32'(exp_pc));
        tick();
        chk("fetch_valid_pulse", 32'(ir_valid), 32'd0);
    endtask

    typedef struct {
        int          lat;
        logic [31:0] rdata;
        logic [15:0] addr;
        logic [15:0] pc_f;
        logic        wr;
        logic        sel;
        logic        br;
        logic [15:0] pc_w;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int n;
        total = 0;
        bad   = 0;
        vecs[0] = '{3, 32'h8A12_3456, 16'h0000, 16'h0001, 1'b1, 1'b1, 1'b1, 16'h3456};
        vecs[1] = '{1, 32'h1234_000F, 16'h3456, 16'h3457, 1'b1, 1'b1, 1'b1, 16'h000F};
        vecs[2] = '{2, 32'h2000_FFF0, 16'h000F, 16'h0010, 1'b1, 1'b1, 1'b0, 16'h0000};
        vecs[3] = '{1, 32'h3100_FFF0, 16'h0000, 16'h0001, 1'b1, 1'b1, 1'b1, 16'hFFF0};
        vecs[4] = '{1, 32'h4000_FFFF, 16'hFFF0, 16'hFFF1, 1'b1, 1'b1, 1'b1, 16'hFFFF};
        vecs[5] = '{2, 32'h5000_0005, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0001};
        vecs[6] = '{4, 32'h6789_ABCD, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, 16'h0002};

        rst = 1'b1; ir_load = 1'b0; pc_rst = 1'b0; pc_write = 1'b0;
        pc_sel = 1'b0; br_sel = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
        tick();
        tick();
        check_reset("rst0");
        rst = 1'b0;
        tick();

        // First fetch fields explicitly, then the vector table.
        for (int v = 0; v < 7; v++) begin
            fetch(vecs[v].lat, vecs[v].rdata, vecs[v].addr, vecs[v].pc_f, 1'b0, 1'b0);
            if (v == 0) begin
                chk("v0_opcode", 32'(opcode), 32'h8);
                chk("v0_mm", 32'(mm), 32'hA);
                chk("v0_imm", 32'(imm), 32'h3456);
            end
            pc_write = vecs[v].wr;
            pc_sel   = vecs[v].sel;
            br_sel   = vecs[v].br;
            tick();
            pc_write = 1'b0;
            pc_sel   = 1'b0;
            br_sel   = 1'b0;
            chk("vec_pc_write", 32'(pc_out), 32'(vecs[v].pc_w));
        end

        // Ack coinciding with pc_write (absolute imm=5 from old IR): no increment.
        fetch(1, 32'h7000_0005, 16'h0002, 16'h0003, 1'b0, 1'b0);
        fetch(2, 32'h7100_0009, 16'h0003, 16'h0005, 1'b1, 1'b0);
        // Ack coinciding with pc_rst: IR loads, PC clears.
        fetch(1, 32'h7200_0011, 16'h0005, 16'h0000, 1'b0, 1'b1);

        // pc_rst blocks a fetch request in IDLE.
        ir_load = 1'b1; pc_rst = 1'b1;
        tick();
        ir_load = 1'b0; pc_rst = 1'b0;
        chk("idle_pcrst_noreq", 32'(imem_req), 32'd0);

        // pc_rst mid-request aborts; a late ack is ignored.
        ir_load = 1'b1;
        tick();
        ir_load = 1'b0;
        chk("abort_req", 32'(imem_req), 32'd1);
        tick();
        pc_rst = 1'b1;
        tick();
        pc_rst = 1'b0;
        chk("abort_req_drop", 32'(imem_req), 32'd0);
        chk("abort_busy", 32'(fetch_busy), 32'd0);
        chk("abort_ir", {opcode, mm, rd, rs, imm}, 32'h7200_0011);
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_ack = 1'b0;
        tick();
        chk("abort_stray_ir", {opcode, mm, rd, rs, imm}, 32'h7200_0011);

        // Timeout: no ack for TIMEOUT cycles.
        ir_load = 1'b1;
        tick();
        ir_load = 1'b0;
        n = 0;
        while (fetch_err !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("timeout_cycles", 32'(n), 32'd15);
        chk("timeout_err", 32'(fetch_err), 32'd1);
        chk("timeout_req_drop", 32'(imem_req), 32'd0);
        ir_load = 1'b1;
        tick();
        tick();
        ir_load = 1'b0;
        chk("err_blocks_req", 32'(imem_req), 32'd0);
        imem_ack = 1'b1; imem_rdata = 32'h1111_2222;
        tick();
        imem_ack = 1'b0;
        tick();
        chk("err_stray_ir", {opcode, mm, rd, rs, imm}, 32'h7200_0011);
        chk("err_sticky", 32'(fetch_err), 32'd1);

        rst = 1'b1;
        #1;
        check_reset("rst_err");
        tick();
        rst = 1'b0;
        tick();

        // Reset mid-request; ack one cycle after release is ignored.
        ir_load = 1'b1;
        tick();
        ir_load = 1'b0;
        chk("rstfetch_req", 32'(imem_req), 32'd1);
        rst = 1'b1;
        #1;
        chk("rstfetch_req_async", 32'(imem_req), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        imem_ack = 1'b1; imem_rdata = 32'h9ABC_DEF0;
        tick();
        imem_ack = 1'b0;
        tick();
        check_reset("rstfetch");

        // Halt opcode.
        fetch(2, 32'hF000_0000, 16'h0000, 16'h0001, 1'b0, 1'b0);
        chk("halt_flag", 32'(halted), 32'd1);
        chk("halt_busy", 32'(fetch_busy), 32'd0);
        ir_load = 1'b1;
        tick();
        tick();
        tick();
        ir_load = 1'b0;
        chk("halt_noreq", 32'(imem_req), 32'd0);
        pc_write = 1'b1; pc_sel = 1'b0;
        tick();
        pc_write = 1'b0;
        chk("halt_pc_write", 32'(pc_out), 32'h0002);
        pc_rst = 1'b1;
        tick();
        pc_rst = 1'b0;
        chk("halt_pc_rst", 32'(pc_out), 32'h0000);
        chk("halt_sticky", 32'(halted), 32'd1);
        rst = 1'b1;
        #1;
        check_reset("rst_halt");
        tick();
        rst = 1'b0;
        tick();
        tick();

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
